ysyx_mem_arb: RTL and testbench
===============================

Name: ysyx_mem_arb

Overview:
- Shares the single core memory bus port between the IFU instruction fetch and the EXU load/store path.
- Grants one requester at a time and sequences address and response phases.
- Routes each response back to its owner only.
- Bounds every transaction with a watchdog, so a dead slave cannot hang the pipeline.

Parameters:
BIT_W, 32, data and address width
TIMEOUT_W, 8, width of the watchdog counter; timeout fires after 2**TIMEOUT_W-1 wait cycles

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ifu_avalid  in  1  fetch request, held until ifu_rvalid
ifu_addr  in  BIT_W  fetch address
ifu_rdata  out  BIT_W  fetch data
ifu_rvalid  out  1  fetch response pulse
ifu_err  out  1  fetch error, qualified by ifu_rvalid
lsu_avalid  in  1  load/store request, held until response
lsu_addr  in  BIT_W  load/store address
lsu_ren  in  1  load
lsu_wen  in  1  store
lsu_wdata  in  BIT_W  store data
lsu_wstrb  in  BIT_W/8  byte strobes
lsu_rdata  out  BIT_W  load data
lsu_rvalid  out  1  load response pulse
lsu_wready  out  1  store completion pulse
lsu_err  out  1  error, qualified by lsu_rvalid|lsu_wready
bus_valid  out  1  address phase valid
bus_addr  out  BIT_W  address
bus_wen  out  1  1 = write
bus_wdata  out  BIT_W  write data
bus_wstrb  out  BIT_W/8  write strobes
bus_ready  in  1  slave accepts address phase
bus_rvalid  in  1  read response
bus_bvalid  in  1  write response
bus_rdata  in  BIT_W  read data
bus_err  in  1  response error, qualified by bus_rvalid|bus_bvalid

Behaviour:
- Clock and reset: single clk; rst is asynchronous and active-high.
- Reset: FSM returns to IDLE; owner=IFU; watchdog=0.
- Reset: every output is 0, including the registered bus_* outputs.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: on any avalid, latch owner, addr, wen, wdata and wstrb into registers, then go to REQ. No grant is issued in the same cycle as request detection.
- Fixed priority (default): LSU beats IFU when both are valid in the same cycle.
- REQ: bus_valid=1 and bus_* are driven from the latched registers and stay stable until bus_ready. On bus_valid&bus_ready go to WAIT.
- REQ with a combined accept and response (bus_ready & (bus_rvalid|bus_bvalid) in the same cycle): go straight to RESP.
- WAIT: hold until the expected response arrives — bus_rvalid for a read, bus_bvalid for a write.
- WAIT: a response of the wrong kind is ignored.
- RESP: registered response, so RESP lasts exactly one cycle.
  - Owner IFU: ifu_rvalid=1.
  - Owner LSU: lsu_rvalid=1 for a read, lsu_wready=1 for a write.
  - *_rdata and *_err come from registers captured with the response.
  - Non-owner valid/ready outputs stay 0.
  - Next state is IDLE.
- Latency: min 3 cycles from avalid to response pulse with zero-wait bus (IDLE→REQ→WAIT/RESP).
- Back-to-back: a new request is sampled in IDLE, so there is one idle bubble per transaction.
- Watchdog: counts cycles in REQ+WAIT and clears on IDLE. At its all-ones value, force RESP with err=1 and rdata=0, then go IDLE. A late bus response for an abandoned transaction is ignored in IDLE.
- avalid deasserted mid-transaction: the transaction still completes and its response pulse is still emitted. Requesters discard it.
- lsu_ren and lsu_wen both high: treated as a write. Flag it with an assertion in simulation.
- Async reset mid-transaction: drop bus_valid immediately. Slave-side cleanup is the slave's responsibility.

Optional Feature:
- Macro: YSYX_MEM_ARB_RR_EN.
- When defined: round-robin arbitration. A last_owner flop is updated on each RESP. On a tie in IDLE, grant the non-last owner. last_owner resets to LSU, so IFU wins the first tie.
- When undefined: fixed LSU priority. No last_owner flop is built.

Decomposition:
- Shared package ysyx_mem_arb_pkg:
  - typedef enum logic[1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
  - typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_t;
  - localparam for the watchdog terminal value.
- Sub-module ysyx_mem_arb_pick: combinational grant selection over (ifu_avalid, lsu_avalid, last_owner). It holds the priority vs round-robin logic behind the macro.

Test Plan:
- IFU read, addr=0x8000_0000, bus_ready immediate, bus_rvalid one cycle later with rdata=0x0000_0413 → ifu_rvalid single pulse with ifu_rdata=0x0000_0413; lsu_* stay 0.
- IFU and LSU request in the same cycle, LSU store addr=0x8000_1000, wdata=0xDEAD_BEEF, wstrb=0xF:
  - fixed build: LSU is granted first, bus_wen=1, lsu_wready pulses, then IFU is granted.
  - RR build: IFU is granted first.
- bus_ready held low 5 cycles → bus_addr, bus_wdata and bus_wstrb stable for all 6 REQ cycles; exactly one response pulse.
- No bus response, TIMEOUT_W=4 → after 15 wait cycles lsu_rvalid=1, lsu_err=1, lsu_rdata=0. A late bus_rvalid afterwards produces no pulse.
- rst asserted asynchronously mid-WAIT → bus_valid and all response outputs fall to 0 before the next clk edge; FSM is in IDLE after rst release.
- bus_err=1 on a load response → lsu_rvalid=1 and lsu_err=1 in the same cycle, then IDLE.

Source files
------------

// File: rtl/ysyx_mem_arb_pkg.sv
// ============================================================================
// Module   : ysyx_mem_arb_pkg
// Brief    : Shared types and constants for the IFU/LSU memory bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    localparam int unsigned TIMEOUT_W_DEFAULT = 8;
    // Terminal watchdog count for the default counter width.
    localparam int unsigned WDOG_TERM_DEFAULT = (1 << TIMEOUT_W_DEFAULT) - 1;

endpackage

`default_nettype wire

// File: rtl/ysyx_mem_arb_pick.sv
// ============================================================================
// Module   : ysyx_mem_arb_pick
// Brief    : Combinational grant selection between IFU and LSU requests.
//            Fixed LSU priority by default; YSYX_MEM_ARB_RR_EN selects
//            round-robin on ties using the last owner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_mem_arb_pick
    import ysyx_mem_arb_pkg::*;
(
    input  logic ifu_avalid,
    input  logic lsu_avalid,
`ifdef YSYX_MEM_ARB_RR_EN
    input  logic last_owner,
`endif
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = ifu_avalid | lsu_avalid;
        grant_owner = OWN_IFU;
        if (ifu_avalid && lsu_avalid) begin
`ifdef YSYX_MEM_ARB_RR_EN
            grant_owner = (last_owner == OWN_LSU) ? OWN_IFU : OWN_LSU;
`else
            grant_owner = OWN_LSU;
`endif
        end else if (lsu_avalid) begin
            grant_owner = OWN_LSU;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_mem_arb.sv
// ============================================================================
// Module   : ysyx_mem_arb
// Brief    : Shares one memory bus port between IFU fetch and LSU load/store,
//            with a watchdog bounding every transaction.
//            Optional macro YSYX_MEM_ARB_RR_EN enables round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_mem_arb
    import ysyx_mem_arb_pkg::*;
#(
    parameter int BIT_W     = 32,
    parameter int TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ifu_avalid,
    input  logic [BIT_W-1:0]   ifu_addr,
    output logic [BIT_W-1:0]   ifu_rdata,
    output logic               ifu_rvalid,
    output logic               ifu_err,
    input  logic               lsu_avalid,
    input  logic [BIT_W-1:0]   lsu_addr,
    input  logic               lsu_ren,
    input  logic               lsu_wen,
    input  logic [BIT_W-1:0]   lsu_wdata,
    input  logic [BIT_W/8-1:0] lsu_wstrb,
    output logic [BIT_W-1:0]   lsu_rdata,
    output logic               lsu_rvalid,
    output logic               lsu_wready,
    output logic               lsu_err,
    output logic               bus_valid,
    output logic [BIT_W-1:0]   bus_addr,
    output logic               bus_wen,
    output logic [BIT_W-1:0]   bus_wdata,
    output logic [BIT_W/8-1:0] bus_wstrb,
    input  logic               bus_ready,
    input  logic               bus_rvalid,
    input  logic               bus_bvalid,
    input  logic [BIT_W-1:0]   bus_rdata,
    input  logic               bus_err
);

    localparam int STRB_W = BIT_W / 8;
    localparam logic [TIMEOUT_W-1:0] WDOG_TERM = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    arb_state_t           state_q, state_d;
    arb_owner_t           owner_q, owner_d;
    logic [BIT_W-1:0]     addr_q,  addr_d;
    logic [BIT_W-1:0]     wdata_q, wdata_d;
    logic [BIT_W-1:0]     rdata_q, rdata_d;
    logic [STRB_W-1:0]    wstrb_q, wstrb_d;
    logic                 wen_q,   wen_d;
    logic                 err_q,   err_d;
    logic [TIMEOUT_W-1:0] wdog_q,  wdog_d;

    logic grant_valid;
    logic grant_owner;
    logic resp_hit;
    logic wdog_fire;
    logic resp_ifu;
    logic resp_lsu;

`ifdef YSYX_MEM_ARB_RR_EN
    arb_owner_t last_owner_q, last_owner_d;

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == RESP) begin
            last_owner_d = owner_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= OWN_LSU;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    ysyx_mem_arb_pick u_pick (
        .ifu_avalid  (ifu_avalid),
        .lsu_avalid  (lsu_avalid),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );
`else
    ysyx_mem_arb_pick u_pick (
        .ifu_avalid  (ifu_avalid),
        .lsu_avalid  (lsu_avalid),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );
`endif

    // Only the response kind matching the latched direction completes a beat.
    assign resp_hit  = wen_q ? bus_bvalid : bus_rvalid;
    assign wdog_fire = (wdog_q == WDOG_TERM);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        wen_d   = wen_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (grant_valid) begin
                    owner_d = arb_owner_t'(grant_owner);
                    state_d = REQ;
                    if (grant_owner == OWN_LSU) begin
                        addr_d  = lsu_addr;
                        wen_d   = lsu_wen;
                        wdata_d = lsu_wdata;
                        wstrb_d = lsu_wstrb;
                    end else begin
                        addr_d  = ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                end
            end
            REQ: begin
                wdog_d = wdog_q + WDOG_ONE;
                if (bus_ready && resp_hit) begin
                    rdata_d = bus_rdata;
                    err_d   = bus_err;
                    state_d = RESP;
                end else if (wdog_fire) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (bus_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wdog_d = wdog_q + WDOG_ONE;
                if (resp_hit) begin
                    rdata_d = bus_rdata;
                    err_d   = bus_err;
                    state_d = RESP;
                end else if (wdog_fire) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                wdog_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    assign bus_valid = (state_q == REQ);
    assign bus_addr  = addr_q;
    assign bus_wen   = wen_q;
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;

    assign resp_ifu = (state_q == RESP) && (owner_q == OWN_IFU);
    assign resp_lsu = (state_q == RESP) && (owner_q == OWN_LSU);

    assign ifu_rvalid = resp_ifu;
    assign ifu_rdata  = resp_ifu ? rdata_q : '0;
    assign ifu_err    = resp_ifu & err_q;
    assign lsu_rvalid = resp_lsu & ~wen_q;
    assign lsu_wready = resp_lsu & wen_q;
    assign lsu_rdata  = resp_lsu ? rdata_q : '0;
    assign lsu_err    = resp_lsu & err_q;

`ifndef SYNTHESIS
    // A request with both load and store set is executed as a store.
    ren_wen_excl_a: assert property (@(posedge clk) disable iff (rst)
        !(lsu_avalid && lsu_ren && lsu_wen));
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_mem_arb.sv
// ============================================================================
// Module   : tb_ysyx_mem_arb
// Brief    : Scoreboard bench for ysyx_mem_arb with a scripted bus slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_mem_arb;

    localparam int BIT_W = 32;
    localparam int TW    = 4;
    localparam int K_IFU = 0;
    localparam int K_LRD = 1;
    localparam int K_LWR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_avalid = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic [31:0] ifu_rdata;
    logic        ifu_rvalid, ifu_err;
    logic        lsu_avalid = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic        lsu_ren = 1'b0, lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid, lsu_wready, lsu_err;
    logic        bus_valid, bus_wen;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready = 1'b0, bus_rvalid = 1'b0, bus_bvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;

    always #5 clk = ~clk;

    ysyx_mem_arb #(.BIT_W(BIT_W), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst),
        .ifu_avalid(ifu_avalid), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata),
        .ifu_rvalid(ifu_rvalid), .ifu_err(ifu_err),
        .lsu_avalid(lsu_avalid), .lsu_addr(lsu_addr), .lsu_ren(lsu_ren),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_wready(lsu_wready),
        .lsu_err(lsu_err),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wen(bus_wen),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_bvalid(bus_bvalid), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    typedef struct {
        int          kind;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    resp_t exp_q[$];
    bus_t  bus_q[$];
    resp_t mr;
    bus_t  mb;

    int total    = 0;
    int bad      = 0;
    int resp_cnt = 0;

    // Slave script knobs
    int          cfg_rdy   = 0;
    int          cfg_rsp   = 0;
    int          cfg_late  = 0;
    bit          cfg_nores = 1'b0;
    logic [31:0] cfg_rdata = '0;
    logic        cfg_err   = 1'b0;
    bit          slave_busy = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_resp(input int k, input logic [31:0] d, input logic e);
        resp_t r;
        r.kind = k; r.rdata = d; r.err = e;
        exp_q.push_back(r);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        bus_t b;
        b.addr = a; b.wen = w; b.wdata = d; b.wstrb = s;
        bus_q.push_back(b);
    endtask

    // Response monitor: DUT outputs only change on posedge, so negedge is safe.
    always @(negedge clk) begin
        if (!rst && (ifu_rvalid || lsu_rvalid || lsu_wready)) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: got ifu=%0b lrd=%0b lwr=%0b want none",
                         ifu_rvalid, lsu_rvalid, lsu_wready);
            end else begin
                mr = exp_q.pop_front();
                chk("resp_kind", 96'({ifu_rvalid, lsu_rvalid, lsu_wready}),
                    96'((mr.kind == K_IFU) ? 3'b100 : (mr.kind == K_LRD) ? 3'b010 : 3'b001));
                if (mr.kind == K_IFU) begin
                    chk("ifu_rdata", 96'(ifu_rdata), 96'(mr.rdata));
                    chk("ifu_err", 96'(ifu_err), 96'(mr.err));
                end else begin
                    if (mr.kind == K_LRD) chk("lsu_rdata", 96'(lsu_rdata), 96'(mr.rdata));
                    chk("lsu_err", 96'(lsu_err), 96'(mr.err));
                end
            end
        end
    end

    // Scripted slave; also checks each accepted address phase.
    logic [31:0] sa, sd;
    logic [3:0]  ss;
    logic        sw;
    initial begin
        forever begin
            @(negedge clk);
            if (bus_valid && !rst) begin
                slave_busy = 1'b1;
                sa = bus_addr; sd = bus_wdata; ss = bus_wstrb; sw = bus_wen;
                for (int i = 0; i < cfg_rdy; i++) begin
                    @(negedge clk);
                    chk("req_stable", 96'({bus_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb}),
                        96'({1'b1, sa, sw, sd, ss}));
                end
                if (bus_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL bus_unexpected: got addr=%0h want none", bus_addr);
                end else begin
                    mb = bus_q.pop_front();
                    chk("bus_phase", 96'({bus_addr, bus_wen, bus_wdata, bus_wstrb}),
                        96'({mb.addr, mb.wen, mb.wdata, mb.wstrb}));
                end
                bus_ready = 1'b1;
                @(negedge clk);
                bus_ready = 1'b0;
                if (!cfg_nores) begin
                    repeat (cfg_rsp) @(negedge clk);
                    bus_rvalid = !sw; bus_bvalid = sw; bus_rdata = cfg_rdata; bus_err = cfg_err;
                    @(negedge clk);
                    bus_rvalid = 1'b0; bus_bvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
                end else if (cfg_late > 0) begin
                    repeat (cfg_late) @(negedge clk);
                    bus_rvalid = 1'b1; bus_rdata = cfg_rdata;
                    @(negedge clk);
                    bus_rvalid = 1'b0; bus_rdata = '0;
                end
                slave_busy = 1'b0;
            end
        end
    end

    // Requester tasks: called on a negedge, hold the request until its pulse.
    task automatic ifu_txn(input logic [31:0] a, output int lat);
        bit got = 1'b0;
        ifu_avalid = 1'b1; ifu_addr = a; lat = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (ifu_rvalid) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL ifu_wait: got no pulse want pulse within 100 cycles");
        end
        ifu_avalid = 1'b0;
    endtask

    task automatic lsu_txn(input logic [31:0] a, input logic we, input logic [31:0] d,
                           input logic [3:0] s, output int lat);
        bit got = 1'b0;
        lsu_avalid = 1'b1; lsu_addr = a; lsu_ren = !we; lsu_wen = we;
        lsu_wdata = d; lsu_wstrb = s; lat = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (lsu_rvalid || lsu_wready) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL lsu_wait: got no pulse want pulse within 100 cycles");
        end
        lsu_avalid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    endtask

    task automatic settle();
        for (int i = 0; i < 200 && (slave_busy || exp_q.size() != 0); i++) @(negedge clk);
        if (slave_busy || exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL settle: got pending=%0d want 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic any_out();
        return |{ifu_rdata, ifu_rvalid, ifu_err, lsu_rdata, lsu_rvalid, lsu_wready,
                 lsu_err, bus_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb};
    endfunction

    int lat_a, lat_b, cnt0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", 96'(any_out()), 96'(0));
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous IFU read and LSU store
        cfg_rdy = 0; cfg_rsp = 0; cfg_rdata = 32'hCAFE_0001; cfg_err = 1'b0;
`ifdef YSYX_MEM_ARB_RR_EN
        push_bus(32'h8000_0100, 1'b0, 32'h0, 4'h0);
        push_resp(K_IFU, 32'hCAFE_0001, 1'b0);
        push_bus(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
        push_resp(K_LWR, 32'h0, 1'b0);
`else
        push_bus(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
        push_resp(K_LWR, 32'h0, 1'b0);
        push_bus(32'h8000_0100, 1'b0, 32'h0, 4'h0);
        push_resp(K_IFU, 32'hCAFE_0001, 1'b0);
`endif
        fork
            lsu_txn(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, lat_a);
            ifu_txn(32'h8000_0100, lat_b);
        join
        settle();

        // IFU read with zero-wait bus: 3-cycle latency, single pulse
        cnt0 = resp_cnt;
        cfg_rdata = 32'h0000_0413;
        push_bus(32'h8000_0000, 1'b0, 32'h0, 4'h0);
        push_resp(K_IFU, 32'h0000_0413, 1'b0);
        ifu_txn(32'h8000_0000, lat_a);
        chk("ifu_latency", 96'(lat_a), 96'(3));
        settle();
        chk("ifu_pulses", 96'(resp_cnt - cnt0), 96'(1));

        // LSU read with bus_ready held low for 5 cycles
        cnt0 = resp_cnt;
        cfg_rdy = 5; cfg_rdata = 32'h1122_3344;
        push_bus(32'h8000_0040, 1'b0, 32'h0, 4'h0);
        push_resp(K_LRD, 32'h1122_3344, 1'b0);
        lsu_txn(32'h8000_0040, 1'b0, 32'h0, 4'h0, lat_a);
        settle();
        chk("stall_pulses", 96'(resp_cnt - cnt0), 96'(1));
        cfg_rdy = 0;

        // Load with bus_err
        cfg_rdata = 32'h5555_AAAA; cfg_err = 1'b1;
        push_bus(32'h8000_0080, 1'b0, 32'h0, 4'h0);
        push_resp(K_LRD, 32'h5555_AAAA, 1'b1);
        lsu_txn(32'h8000_0080, 1'b0, 32'h0, 4'h0, lat_a);
        settle();
        cfg_err = 1'b0;

        // Dead slave: watchdog forces an error response, late response ignored
        cnt0 = resp_cnt;
        cfg_nores = 1'b1; cfg_late = 20; cfg_rdata = 32'h7777_7777;
        push_bus(32'h8000_00C0, 1'b0, 32'h0, 4'h0);
        push_resp(K_LRD, 32'h0, 1'b1);
        lsu_txn(32'h8000_00C0, 1'b0, 32'h0, 4'h0, lat_a);
        chk("timeout_latency", 96'(lat_a), 96'(17));
        settle();
        chk("timeout_pulses", 96'(resp_cnt - cnt0), 96'(1));
        cfg_late = 0;

        // Asynchronous reset while waiting for a response
        cnt0 = resp_cnt;
        push_bus(32'h8000_3000, 1'b0, 32'h0, 4'h0);
        lsu_avalid = 1'b1; lsu_addr = 32'h8000_3000; lsu_ren = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", 96'(any_out()), 96'(0));
        lsu_avalid = 1'b0; lsu_ren = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cfg_nores = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", 96'(bus_valid), 96'(0));
        chk("post_reset_pulses", 96'(resp_cnt - cnt0), 96'(0));

        // Partial-strobe store with delayed response, then a fetch
        cfg_rsp = 2; cfg_rdata = 32'h0;
        push_bus(32'h8000_1004, 1'b1, 32'h0102_0304, 4'h3);
        push_resp(K_LWR, 32'h0, 1'b0);
        lsu_txn(32'h8000_1004, 1'b1, 32'h0102_0304, 4'h3, lat_a);
        settle();
        cfg_rsp = 0; cfg_rdata = 32'h0000_0097;
        push_bus(32'h8000_0004, 1'b0, 32'h0, 4'h0);
        push_resp(K_IFU, 32'h0000_0097, 1'b0);
        ifu_txn(32'h8000_0004, lat_a);
        settle();
        chk("bus_queue_empty", 96'(bus_q.size()), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish before 100000");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire
